// File: rtl/alpha_mean_pkg.sv
// Purpose: shared FSM encoding, sizing functions and bus field helper for the alpha-trim mean block.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package alpha_mean_pkg;

  // One-hot controller states.
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    WAIT = 6'b000010,
    ARM  = 6'b000100,
    ACC  = 6'b001000,
    DIV  = 6'b010000,
    OUT  = 6'b100000
  } state_e;

  // Widest packed bus get_field() can slice; callers zero-extend to this width.
  localparam int MAX_BUS = 512;

  // Number of central samples kept after trimming.
  function automatic int calc_k(input int dn, input int trim);
    return dn - 2 * trim;
  endfunction

  // Accumulator width: K samples of dw bits, plus the K/2 rounding term, never overflow.
  function automatic int calc_sw(input int dw, input int k);
    return dw + $clog2(k + 1);
  endfunction

  // Field r of width w (w <= 31) from a packed bus with field 0 at the LSBs.
  function automatic logic [31:0] get_field(input logic [MAX_BUS-1:0] bus, input int r, input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return 32'(bus >> (r * w)) & mask;
  endfunction

endpackage

// File: rtl/trim_mean_div.sv
// Purpose: bit-serial restoring divider, dividend / K for a constant divisor K.
// Latency: SW cycles; the first step runs in the start cycle, done pulses in the SW-th cycle.
// Backpressure: none; a start while busy restarts the division.
// Ports: clk, rst (async, active-high); start (1-cycle pulse, dividend valid that cycle);
//        dividend[SW]; quotient[QW] (valid while done is high); done (1-cycle pulse).
module trim_mean_div #(
  parameter int SW = 12,
  parameter int K  = 13,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  output logic [QW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(SW + 1);

  logic [SW-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [SW-1:0] src_quo, src_rem, rem_step, quo_step;
  logic [SW:0]   shifted;
  logic [CW-1:0] cnt_step;
  logic          q_bit, active;

  always_comb begin
    // On start the first step consumes the dividend directly, so no load cycle is lost.
    src_quo  = start ? dividend : quo_q;
    src_rem  = start ? '0 : rem_q;
    shifted  = {src_rem, src_quo[SW-1]};
    q_bit    = 1'b0;
    rem_step = shifted[SW-1:0];
    if (shifted >= (SW+1)'(K)) begin
      q_bit    = 1'b1;
      rem_step = SW'(shifted - (SW+1)'(K));
    end
    quo_step = {src_quo[SW-2:0], q_bit};
    active   = start | busy_q;
    cnt_step = start ? CW'(1) : cnt_q + CW'(1);
    done     = active && (cnt_step == CW'(SW));
    quotient = quo_step[QW-1:0];

    rem_d  = active ? rem_step : rem_q;
    quo_d  = active ? quo_step : quo_q;
    cnt_d  = active ? cnt_step : cnt_q;
    busy_d = active & ~done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alpha_trim_mean.sv
// Purpose: rounded mean of the DN-2*TRIM central samples of a sorted window (alpha-trimmed mean).
// Latency: sort_finish in cycle t -> mean_valid in cycle t+K+SW+2 (27 with defaults).
// Backpressure: none; a sort_sig while busy is dropped and flagged on overrun the next cycle.
// Ports: clk, rst (async, active-high); sort_sig + data_unsort (window strobe/data);
//        sort_finish + sequence_sorted (rank -> original index, valid the cycle after sort_finish);
//        mean_out (held), mean_valid (pulse), busy (not IDLE), overrun (pulse).
module alpha_trim_mean
  import alpha_mean_pkg::*;
#(
  parameter int DN          = 25,
  parameter int DW          = 8,
  parameter int DW_sequence = $clog2(DN),
  parameter int TRIM        = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sort_sig,
  input  logic [DW*DN-1:0]          data_unsort,
  input  logic                      sort_finish,
  input  logic [DW_sequence*DN-1:0] sequence_sorted,
  output logic [DW-1:0]             mean_out,
  output logic                      mean_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int K  = calc_k(DN, TRIM);
  localparam int SW = calc_sw(DW, K);

  if (2 * TRIM >= DN) begin : g_bad_trim
    $error("alpha_trim_mean: 2*TRIM must be smaller than DN");
  end
  if (DW * DN > MAX_BUS || DW_sequence * DN > MAX_BUS) begin : g_bad_bus
    $error("alpha_trim_mean: window bus wider than MAX_BUS");
  end

  state_e                    state_q, state_d;
  logic [DW*DN-1:0]          data_q, data_d;
  logic [DW_sequence*DN-1:0] seq_q, seq_d;
  logic [SW-1:0]             sum_q, sum_d;
  logic [DW_sequence-1:0]    rank_q, rank_d;
  logic [DW-1:0]             mean_q, mean_d;
  logic                      mean_valid_q, mean_valid_d;
  logic                      overrun_q, overrun_d;
  logic                      div_start_q, div_start_d;

  logic [31:0]   idx;
  logic [DW-1:0] sample;
  logic [SW-1:0] dividend;
  logic [DW-1:0] quotient;
  logic          div_done;

  // Sample mux: sample[seq[rank]]; an out-of-range index reads as zero.
  always_comb begin
    idx    = get_field(MAX_BUS'(seq_q), int'(rank_q), DW_sequence);
    sample = '0;
    if (idx < 32'(DN)) begin
      sample = DW'(get_field(MAX_BUS'(data_q), int'(idx), DW));
    end
  end

  // Adding K/2 before the floor divide rounds to nearest.
  assign dividend = sum_q + SW'(K / 2);

  trim_mean_div #(
    .SW(SW),
    .K (K),
    .QW(DW)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start_q),
    .dividend(dividend),
    .quotient(quotient),
    .done    (div_done)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    seq_d        = seq_q;
    sum_d        = sum_q;
    rank_d       = rank_q;
    mean_d       = mean_q;
    mean_valid_d = 1'b0;
    div_start_d  = 1'b0;
    overrun_d    = sort_sig && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // sort_sig has priority; a coincident sort_finish is simply not looked at here.
        if (sort_sig) begin
          data_d  = data_unsort;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sort_finish) state_d = ARM;
      end
      ARM: begin
        seq_d   = sequence_sorted;
        sum_d   = '0;
        rank_d  = DW_sequence'(TRIM);
        state_d = ACC;
      end
      ACC: begin
        sum_d  = sum_q + SW'(sample);
        rank_d = rank_q + DW_sequence'(1);
        if (rank_q == DW_sequence'(DN - TRIM - 1)) begin
          div_start_d = 1'b1;
          state_d     = DIV;
        end
      end
      DIV: begin
        // Result is loaded on entry to OUT so mean_out and mean_valid appear together.
        if (div_done) begin
          mean_d       = quotient;
          mean_valid_d = 1'b1;
          state_d      = OUT;
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      seq_q        <= '0;
      sum_q        <= '0;
      rank_q       <= '0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      div_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      seq_q        <= seq_d;
      sum_q        <= sum_d;
      rank_q       <= rank_d;
      mean_q       <= mean_d;
      mean_valid_q <= mean_valid_d;
      overrun_q    <= overrun_d;
      div_start_q  <= div_start_d;
    end
  end

  assign mean_out   = mean_q;
  assign mean_valid = mean_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Purpose: self-checking bench for alpha_trim_mean with a sorter stand-in and a trimmed-mean model.
// Latency: expects mean_valid exactly 27 cycles after the cycle sort_finish is high.
// Backpressure: checks overrun pulses and that dropped strobes leave the result untouched.
module tb_alpha_trim_mean;

  localparam int DN   = 25;
  localparam int DW   = 8;
  localparam int SQW  = 5;
  localparam int TRIM = 6;
  localparam int KK   = DN - 2 * TRIM;
  localparam int LAT  = 27;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sort_sig = 1'b0;
  logic               sort_finish = 1'b0;
  logic [DW*DN-1:0]   data_unsort = '0;
  logic [SQW*DN-1:0]  sequence_sorted = '0;
  logic [DW-1:0]      mean_out;
  logic               mean_valid;
  logic               busy;
  logic               overrun;

  alpha_trim_mean #(.DN(DN), .DW(DW), .DW_sequence(SQW), .TRIM(TRIM)) dut (
    .clk            (clk),
    .rst            (rst),
    .sort_sig       (sort_sig),
    .data_unsort    (data_unsort),
    .sort_finish    (sort_finish),
    .sequence_sorted(sequence_sorted),
    .mean_out       (mean_out),
    .mean_valid     (mean_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Model state: when the result is due, its value, the held output, busy span, overrun cycle.
  int pend_cyc = -1;
  int pend_val = 0;
  int held = 0;
  int busy_lo = -1;
  int busy_hi = -2;
  int ovr_cyc = -1;
  int valid_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_mean_out", int'(mean_out), 0);
      check("rst_mean_valid", int'(mean_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
    end else begin
      if (cyc == pend_cyc) held = pend_val;
      check("mean_valid", int'(mean_valid), (cyc == pend_cyc) ? 1 : 0);
      check("mean_out", int'(mean_out), held);
      check("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      check("overrun", int'(overrun), (cyc == ovr_cyc) ? 1 : 0);
    end
    if (mean_valid) valid_seen++;
  end

  function automatic logic [DW*DN-1:0] rand_data();
    logic [DW*DN-1:0] b;
    for (int i = 0; i < DN; i++) b[i*DW +: DW] = DW'($urandom);
    return b;
  endfunction

  function automatic logic [SQW*DN-1:0] rand_seq();
    logic [SQW*DN-1:0] b;
    for (int i = 0; i < DN; i++) b[i*SQW +: SQW] = SQW'($urandom);
    return b;
  endfunction

  // One window. Offsets k are cycles after the strobe cycle. ovr_off/stray_off <= 0 disables them.
  // both: sort_finish also high in the strobe cycle. bad_rank >= 0 corrupts that rank to index 31.
  task automatic run_window(input int s[DN], input int fin_off, input int ovr_off, input int stray_off,
                            input bit both, input int bad_rank, input int lit);
    int ord[DN];
    int sum, expv, a, seen0, key, j;
    logic [SQW*DN-1:0] seq_bus;
    logic [DW*DN-1:0]  dbus;
    for (int i = 0; i < DN; i++) ord[i] = i;
    for (int i = 1; i < DN; i++) begin
      key = ord[i];
      j = i - 1;
      while (j >= 0 && s[ord[j]] > s[key]) begin
        ord[j+1] = ord[j];
        j--;
      end
      ord[j+1] = key;
    end
    if (bad_rank >= 0) ord[bad_rank] = 31;
    sum = 0;
    for (int r = TRIM; r < DN - TRIM; r++) sum += (ord[r] < DN) ? s[ord[r]] : 0;
    expv = (sum + KK / 2) / KK;
    if (lit >= 0) check("model_pin", expv, lit);
    for (int i = 0; i < DN; i++) begin
      seq_bus[i*SQW +: SQW] = SQW'(ord[i]);
      dbus[i*DW +: DW]      = DW'(s[i]);
    end

    @(posedge clk); #1;
    a           = cyc;
    data_unsort = dbus;
    sort_sig    = 1'b1;
    sort_finish = both;
    busy_lo     = a + 1;
    busy_hi     = a + fin_off + LAT;
    pend_cyc    = a + fin_off + LAT;
    pend_val    = expv;
    ovr_cyc     = (ovr_off > 0) ? a + ovr_off + 1 : -1;
    seen0       = valid_seen;
    for (int k = 1; k <= fin_off + LAT + 2; k++) begin
      @(posedge clk); #1;
      sort_sig        = (k == ovr_off);
      sort_finish     = (k == fin_off) || (k == stray_off);
      data_unsort     = rand_data();
      sequence_sorted = (k == fin_off + 1) ? seq_bus : rand_seq();
    end
    sort_sig    = 1'b0;
    sort_finish = 1'b0;
    check("valid_count", valid_seen - seen0, 1);
    if (lit >= 0) check("mean_lit", int'(mean_out), lit);
  endtask

  task automatic run_reset_mid(input int s[DN]);
    int seen0;
    logic [DW*DN-1:0] dbus;
    for (int i = 0; i < DN; i++) dbus[i*DW +: DW] = DW'(s[i]);
    @(posedge clk); #1;
    data_unsort = dbus;
    sort_sig    = 1'b1;
    busy_lo     = cyc + 1;
    busy_hi     = cyc + 3 + LAT;
    pend_cyc    = cyc + 3 + LAT;
    pend_val    = 77;
    ovr_cyc     = -1;
    seen0       = valid_seen;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      sort_sig        = 1'b0;
      sort_finish     = (k == 3);
      sequence_sorted = rand_seq();
      if (k == 10) begin
        // Mid-accumulate: the window is abandoned and the model forgets it.
        rst      = 1'b1;
        pend_cyc = -1;
        held     = 0;
        busy_lo  = -1;
        busy_hi  = -2;
      end
      if (k == 12) rst = 1'b0;
    end
    check("valid_after_rst", valid_seen - seen0, 0);
  endtask

  int s_const[DN], s_ramp[DN], s_mix[DN], s_hi[DN], s_lo[DN];

  initial begin
    for (int i = 0; i < DN; i++) begin
      s_const[i] = 100;
      s_ramp[i]  = i;
      s_mix[(i * 7) % DN] = (i < 6) ? 0 : (i < 18) ? 10 : (i == 18) ? 17 : 255;
      s_hi[i] = (i % 4 == 1 && i < 24) ? 255 : 50;
      s_lo[i] = (i % 4 == 1 && i < 24) ? 0 : 50;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_window(s_const, 3, -1, -1, 1'b0, -1, 100);       // all equal, latency
    run_window(s_ramp, 5, -1, -1, 1'b0, -1, 12);         // ramp 0..24
    run_window(s_mix, 2, -1, -1, 1'b0, -1, 11);          // rounds up
    run_window(s_hi, 4, -1, -1, 1'b0, -1, 50);           // large outliers
    run_window(s_lo, 4, -1, -1, 1'b0, -1, 50);           // small outliers
    run_window(s_ramp, 8, 5, 8 + 6, 1'b0, -1, 12);       // overrun + stray sort_finish in ACC
    run_reset_mid(s_mix);
    run_window(s_mix, 3, -1, -1, 1'b0, -1, 11);          // clean window after reset
    run_window(s_const, 4, -1, -1, 1'b1, -1, 100);       // sort_sig + sort_finish together
    run_window(s_hi, 2, 2 + LAT, -1, 1'b0, -1, 50);      // strobe in OUT dropped
    run_window(s_const, 3, -1, -1, 1'b0, 10, 92);        // invalid index reads as 0

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
